// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC register and the IF/ID pipeline
// register, drives a req/ack instruction-memory interface, and absorbs
// hazard stalls and control-flow redirects (including redirects that land
// on a fetch still outstanding in memory).
//
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   next_pc      resolved next PC from the next-PC select logic
//   redirect     next_pc is a branch/jump target; flush IF/ID
//   stall        hazard unit hold of PC and IF/ID
//   pc, pcp4     current fetch PC and pc+4 (combinational)
//   imem_req     fetch request, held until imem_ack
//   imem_addr    fetch address, stable while imem_req is high
//   imem_rdata   instruction word, valid with imem_ack
//   imem_ack     one-cycle completion pulse
//   ifid_instr   IF/ID instruction word
//   ifid_pcp4    IF/ID pc+4 of that instruction
//   ifid_valid   IF/ID holds a real instruction (0 = bubble)
//
// state | meaning
// FETCH | request outstanding (or about to issue after reset)
// HELD  | word returned during a stall, parked in the skid register
// DROP  | redirected while a fetch was outstanding; wait for and discard it
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pcp4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcp4,
    output logic        ifid_valid
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HELD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_addr;
    logic [31:0] skid;
    logic        ack_seen;

    // An ack with no request outstanding is not a completion.
    assign ack_seen  = imem_ack & imem_req;
    assign pcp4      = pc + 32'd4;
    assign imem_addr = fetch_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            imem_req   <= 1'b0;
            skid       <= NOP_INSTR;
            ifid_instr <= NOP_INSTR;
            ifid_pcp4  <= 32'h0000_0000;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            // Redirect overrides stall: the pipeline behind is being flushed.
            pc         <= next_pc;
            skid       <= NOP_INSTR;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem_req && !imem_ack) begin
                        // Memory is still working on the old address; it
                        // cannot be cancelled, so wait it out in DROP.
                        state <= ST_DROP;
                    end else begin
                        imem_req   <= 1'b1;
                        fetch_addr <= next_pc;
                    end
                end
                ST_HELD: begin
                    state      <= ST_FETCH;
                    imem_req   <= 1'b1;
                    fetch_addr <= next_pc;
                end
                ST_DROP: begin
                    if (ack_seen) begin
                        state      <= ST_FETCH;
                        fetch_addr <= next_pc;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ack_seen) begin
                        if (!stall) begin
                            ifid_instr <= imem_rdata;
                            ifid_pcp4  <= pcp4;
                            ifid_valid <= 1'b1;
                            pc         <= next_pc;
                            fetch_addr <= next_pc;
                        end else begin
                            skid     <= imem_rdata;
                            imem_req <= 1'b0;
                            state    <= ST_HELD;
                        end
                    end else begin
                        if (!imem_req) begin
                            imem_req   <= 1'b1;
                            fetch_addr <= pc;
                        end
                        if (!stall) begin
                            ifid_instr <= NOP_INSTR;
                            ifid_valid <= 1'b0;
                        end
                    end
                end
                ST_HELD: begin
                    // pc still addresses the parked word, so pcp4 is its pc+4.
                    if (!stall) begin
                        ifid_instr <= skid;
                        ifid_pcp4  <= pcp4;
                        ifid_valid <= 1'b1;
                        pc         <= next_pc;
                        fetch_addr <= next_pc;
                        imem_req   <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // Returned word belongs to the abandoned path; refetch at pc.
                    if (ack_seen) begin
                        state      <= ST_FETCH;
                        fetch_addr <= pc;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcp4;
    logic        ifid_valid;

    logic [31:0] tgt;
    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    // Memory model returns a word derived from the address; next-PC logic
    // is pc+4 unless the bench is redirecting.
    assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;
    assign next_pc    = redirect ? tgt : pcp4;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .pc         (pc),
        .pcp4       (pcp4),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .ifid_instr (ifid_instr),
        .ifid_pcp4  (ifid_pcp4),
        .ifid_valid (ifid_valid)
    );

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
        tgt      = 32'h0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_tests++; if (pcp4 !== 32'h4) begin n_fail++; $display("FAIL reset_pcp4: got %h want %h", pcp4, 32'h4); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b0, NOP, 32'h0}) begin
            n_fail++; $display("FAIL reset_ifid: got %b %h %h want 0 %h 0", ifid_valid, ifid_instr, ifid_pcp4, NOP);
        end
        @(negedge clk);
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL reset_first_req: got %b %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_fetch_stream();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
                n_fail++; $display("FAIL stream_addr%0d: got %b %h want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
            end
            imem_ack = 1'b1;
            sb.push_back('{instr: word(32'(4 * i)), pcp4: 32'(4 * i + 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
                n_fail++; $display("FAIL stream_ifid%0d: got %b %h %h want 1 %h %h", i, ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_stall_skid();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b1;
            sb.push_back('{instr: word(32'(4 * i)), pcp4: 32'(4 * i + 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
                n_fail++; $display("FAIL skid_pre%0d: got %b %h %h want 1 %h %h", i, ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
            end
        end
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_req_low%0d: got %b want 0", c, imem_req); end
            n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, word(32'h4), 32'h8}) begin
                n_fail++; $display("FAIL skid_hold%0d: got %b %h %h want 1 %h 00000008", c, ifid_valid, ifid_instr, ifid_pcp4, word(32'h4));
            end
        end
        stall = 1'b0;
        sb.push_back('{instr: word(32'h8), pcp4: 32'hC});
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
            n_fail++; $display("FAIL skid_release: got %b %h %h want 1 %h %h", ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
        end
        n_tests++; if ({imem_req, imem_addr, pc} !== {1'b1, 32'hC, 32'hC}) begin
            n_fail++; $display("FAIL skid_next_req: got %b %h pc %h want 1 0000000c pc 0000000c", imem_req, imem_addr, pc);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b1;
            sb.push_back('{instr: word(32'(4 * i)), pcp4: 32'(4 * i + 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_tests++; if ({ifid_valid, ifid_instr} !== {1'b1, e.instr}) begin
                n_fail++; $display("FAIL rpend_pre%0d: got %b %h want 1 %h", i, ifid_valid, ifid_instr, e.instr);
            end
        end
        imem_ack = 1'b0;
        redirect = 1'b1;
        tgt      = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        n_tests++; if ({ifid_valid, ifid_instr, pc} !== {1'b0, NOP, 32'h40}) begin
            n_fail++; $display("FAIL rpend_flush: got %b %h pc %h want 0 %h pc 00000040", ifid_valid, ifid_instr, pc, NOP);
        end
        for (int c = 0; c < 3; c++) begin
            n_tests++; if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h8, 1'b0}) begin
                n_fail++; $display("FAIL rpend_hold%0d: got %b %h v%b want 1 00000008 v0", c, imem_req, imem_addr, ifid_valid);
            end
            if (c < 2) @(negedge clk);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_tests++; if ({imem_req, imem_addr, ifid_valid} !== {1'b1, 32'h40, 1'b0}) begin
            n_fail++; $display("FAIL rpend_dropped: got %b %h v%b want 1 00000040 v0", imem_req, imem_addr, ifid_valid);
        end
        imem_ack = 1'b1;
        sb.push_back('{instr: word(32'h40), pcp4: 32'h44});
        @(negedge clk);
        imem_ack = 1'b0;
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
            n_fail++; $display("FAIL rpend_target: got %b %h %h want 1 %h %h", ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b1;
            sb.push_back('{instr: word(32'(4 * i)), pcp4: 32'(4 * i + 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_tests++; if ({ifid_valid, ifid_instr} !== {1'b1, e.instr}) begin
                n_fail++; $display("FAIL rack_pre%0d: got %b %h want 1 %h", i, ifid_valid, ifid_instr, e.instr);
            end
        end
        imem_ack = 1'b1;
        redirect = 1'b1;
        tgt      = 32'h40;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
        n_tests++; if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
            n_fail++; $display("FAIL rack_bubble: got %b %h want 0 %h", ifid_valid, ifid_instr, NOP);
        end
        n_tests++; if ({imem_req, imem_addr, pc} !== {1'b1, 32'h40, 32'h40}) begin
            n_fail++; $display("FAIL rack_next_req: got %b %h pc %h want 1 00000040 pc 00000040", imem_req, imem_addr, pc);
        end
        imem_ack = 1'b1;
        sb.push_back('{instr: word(32'h40), pcp4: 32'h44});
        @(negedge clk);
        imem_ack = 1'b0;
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
            n_fail++; $display("FAIL rack_target: got %b %h %h want 1 %h %h", ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
        end
    endtask

    task automatic test_redirect_held();
        do_reset();
        @(negedge clk);
        imem_ack = 1'b1;
        sb.push_back('{instr: word(32'h0), pcp4: 32'h4});
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr} !== {1'b1, e.instr}) begin
            n_fail++; $display("FAIL rheld_pre: got %b %h want 1 %h", ifid_valid, ifid_instr, e.instr);
        end
        stall = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b1;
        tgt      = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        stall    = 1'b0;
        n_tests++; if ({ifid_valid, ifid_instr, pc} !== {1'b0, NOP, 32'h80}) begin
            n_fail++; $display("FAIL rheld_flush: got %b %h pc %h want 0 %h pc 00000080", ifid_valid, ifid_instr, pc, NOP);
        end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
            n_fail++; $display("FAIL rheld_req: got %b %h want 1 00000080", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        sb.push_back('{instr: word(32'h80), pcp4: 32'h84});
        @(negedge clk);
        imem_ack = 1'b0;
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
            n_fail++; $display("FAIL rheld_target: got %b %h %h want 1 %h %h", ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
        end
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        redirect = 1'b1;
        tgt      = 32'hFFFF_FFFC;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
        n_tests++; if ({pc, pcp4, imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_pcp4: got pc %h pcp4 %h addr %h want fffffffc 00000000 fffffffc", pc, pcp4, imem_addr);
        end
        imem_ack = 1'b1;
        sb.push_back('{instr: word(32'hFFFF_FFFC), pcp4: 32'h0});
        @(negedge clk);
        imem_ack = 1'b0;
        e = sb.pop_front();
        n_tests++; if ({ifid_valid, ifid_instr, ifid_pcp4} !== {1'b1, e.instr, e.pcp4}) begin
            n_fail++; $display("FAIL wrap_ifid: got %b %h %h want 1 %h %h", ifid_valid, ifid_instr, ifid_pcp4, e.instr, e.pcp4);
        end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_next_req: got %b %h want 1 00000000", imem_req, imem_addr);
        end
        redirect = 1'b1;
        tgt      = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        n_tests++; if ({pc, imem_req, imem_addr} !== {32'h100, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL drop_entry: got pc %h %b %h want 00000100 1 00000000", pc, imem_req, imem_addr);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++; if ({pc, imem_req, ifid_valid, ifid_instr} !== {32'h0, 1'b0, 1'b0, NOP}) begin
            n_fail++; $display("FAIL async_reset: got pc %h req %b v%b %h want 00000000 0 v0 %h", pc, imem_req, ifid_valid, ifid_instr, NOP);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL post_reset_req: got %b %h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    initial begin
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
        tgt      = 32'h0;
        test_reset();
        test_fetch_stream();
        test_stall_skid();
        test_redirect_pending();
        test_redirect_ack();
        test_redirect_held();
        test_wrap_async_reset();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
